uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Adds configurable data width, parity and stop-bit count, plus a double-buffered data path (holding register + shift register) so a byte is accepted while the previous frame is still shifting. It is driven by an external single-cycle baud tick from the baud rate generator and feeds the TxD pin of the SPART/UART top level.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal 1 or 2

Ports:
clk  input  1  system clock; all state on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
baud_tick  input  1  one-clk-wide strobe, one per bit period
transmit_enable  input  1  write strobe; sampled on posedge clk
transmit_buffer  input  DATA_BITS  data to send; LSB transmitted first
TBR  output  1  transmit buffer ready: 1 = holding register empty
TxD  output  1  serial line; idle high; registered
tx_busy  output  1  1 while a frame is on the line (state != IDLE)
tx_done  output  1  one-clk pulse when the last stop bit period ends

Behaviour:
- Reset (reset = 0, asynchronous): TxD = 1, TBR = 1, tx_busy = 0, tx_done = 0, state = IDLE, holding and shift registers cleared, bit counter = 0. Applies immediately, including mid-frame; the partial frame is abandoned.
- Write: on a posedge with transmit_enable = 1 and TBR = 1, transmit_buffer is latched into the holding register and TBR = 0 from the next cycle. A write while TBR = 0 is ignored; the holding contents are unchanged.
- All line transitions occur only on posedge clk with baud_tick = 1. TxD is registered, so it changes one clk after the tick edge. Each bit therefore lasts exactly one baud period.
- States:
  - IDLE: TxD = 1. On a tick with the holding register full: move holding to the shift register, compute parity, go to START, TxD = 0.
  - START: on a tick, go to DATA, TxD = bit0, counter = 0.
  - DATA: on each tick, counter increments and TxD = next bit. After bit DATA_BITS-1 has held for one period, go to PARITY if PARITY_MODE != 0, otherwise to STOP with TxD = 1.
  - PARITY: TxD = parity bit. Even parity = XOR of the data bits; odd parity = its inverse. On a tick, go to STOP, TxD = 1.
  - STOP: lasts STOP_BITS periods. On the tick ending the final stop period, tx_done pulses for one cycle. If the holding register is full, go directly to START: load the shift register, TxD = 0, with no extra idle bit (back-to-back frames). Otherwise go to IDLE.
- TBR rises to 1 the cycle after a holding-to-shift transfer. Throughput of one frame per frame-time is therefore sustained with zero idle gap.
- A transfer and a write never coincide, because a transfer requires TBR = 0.
- Ticks arriving in IDLE with the holding register empty are ignored.
- tx_busy = 1 in START, DATA, PARITY and STOP.
- baud_tick held high for several cycles: each cycle with baud_tick = 1 counts as a tick. The generator guarantees single-cycle strobes.

Optional Feature:
UART_TX_BREAK_EN.
- Defined: adds input send_break (1 bit).
  - While send_break = 1 and state = IDLE, TxD = 0 and frame starts are suppressed; TBR behaves normally.
  - Deasserting send_break returns TxD to 1 on the next clk.
  - A send_break asserted mid-frame takes effect only after the current frame returns to IDLE.
- Not defined: no send_break port; IDLE always drives TxD = 1.

Test Plan:
- Reset idle: release reset, wait 10 clk -> TBR = 1, TxD = 1, tx_busy = 0, tx_done = 0.
- 8N1 frame: write 8'hA5, free-running ticks every 8 clk -> TxD after successive ticks = 0,1,0,1,0,0,1,0,1,1; tx_done pulses once; TBR = 1 one clk after the first tick.
- Parity (PARITY_MODE = 1, then 2; DATA_BITS = 7): write 7'h13 (three ones) -> parity bit 1 for even, 0 for odd; STOP_BITS = 2 gives two high periods before IDLE.
- Back-to-back: write 8'h3C, write 8'hC3 as soon as TBR = 1 -> second start bit begins on the tick ending the first stop bit, no idle gap; write attempted while TBR = 0 -> ignored, 8'hC3 still sent.
- Async reset mid-frame: assert reset during data bit 4 of 8'hFF, off-clock-edge -> TxD = 1 and TBR = 1 immediately; after release, the next write transmits cleanly.
- Break (UART_TX_BREAK_EN): send_break = 1 in IDLE with a byte pending -> TxD = 0, no frame starts; release -> pending frame starts on the next tick.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: DATA_BITS data, optional even/odd parity, 1-2 stop bits, holding + shift register.
// Line changes one clk after a baud_tick edge; TBR low while the holding register is full. Optional UART_TX_BREAK_EN adds send_break.
module uart_tx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 transmit_enable,
  input  logic [DATA_BITS-1:0] transmit_buffer,
`ifdef UART_TX_BREAK_EN
  input  logic                 send_break,
`endif
  output logic                 TBR,
  output logic                 TxD,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [CW-1:0]        cnt;
  logic                 stop_cnt;
  logic                 brk;

`ifdef UART_TX_BREAK_EN
  assign brk = send_break;
`else
  assign brk = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_q   <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      cnt      <= '0;
      stop_cnt <= 1'b0;
      TBR      <= 1'b1;
      TxD      <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      // A write needs TBR=1 and a transfer needs TBR=0, so they never collide.
      if (transmit_enable && TBR) begin
        hold_q <= transmit_buffer;
        TBR    <= 1'b0;
      end
      case (state)
        IDLE: begin
          TxD <= ~brk;
          if (baud_tick && !TBR && !brk) begin
            shift_q  <= hold_q;
            parity_q <= (^hold_q) ^ (PARITY_MODE == 2);
            TBR      <= 1'b1;
            TxD      <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= START;
          end
        end
        START: if (baud_tick) begin
          TxD     <= shift_q[0];
          shift_q <= shift_q >> 1;
          cnt     <= '0;
          state   <= DATA;
        end
        DATA: if (baud_tick) begin
          if (cnt == LAST_BIT) begin
            stop_cnt <= 1'b0;
            if (PARITY_MODE != 0) begin
              TxD   <= parity_q;
              state <= PARITY;
            end else begin
              TxD   <= 1'b1;
              state <= STOP;
            end
          end else begin
            cnt     <= cnt + 1'b1;
            TxD     <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        PARITY: if (baud_tick) begin
          TxD      <= 1'b1;
          stop_cnt <= 1'b0;
          state    <= STOP;
        end
        STOP: if (baud_tick) begin
          if (stop_cnt == STOP_LAST) begin
            tx_done <= 1'b1;
            // Pending data starts straight away so back-to-back frames have no idle bit.
            if (!TBR) begin
              shift_q  <= hold_q;
              parity_q <= (^hold_q) ^ (PARITY_MODE == 2);
              TBR      <= 1'b1;
              TxD      <= 1'b0;
              state    <= START;
            end else begin
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          TxD     <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations (8N1, 7E2, 7O2) checked tick by tick against a frame-level model.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_tick = 1'b0;
  logic [2:0] en = 3'b000;
  logic [7:0] data = 8'h00;
  logic [2:0] tbr, txd, busy, done;
`ifdef UART_TX_BREAK_EN
  logic       send_break = 1'b0;
`endif

  int checks = 0;
  int passes = 0;
  int nb[3] = '{8, 7, 7};
  int pm[3] = '{0, 1, 2};
  int ns[3] = '{1, 2, 2};

  bit exp_txd[$];
  int ends[$];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .transmit_enable(en[0]), .transmit_buffer(data),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .TBR(tbr[0]), .TxD(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .transmit_enable(en[1]), .transmit_buffer(data[6:0]),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .TBR(tbr[1]), .TxD(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .transmit_enable(en[2]), .transmit_buffer(data[6:0]),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .TBR(tbr[2]), .TxD(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  task automatic check(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(int k, logic [7:0] d);
    data  = d;
    en[k] = 1'b1;
    step();
    en[k] = 1'b0;
  endtask

  task automatic clear_model();
    exp_txd.delete();
    ends.delete();
  endtask

  // Append one whole frame as seen on the line: start, data LSB first, parity, stops.
  task automatic build(int k, logic [7:0] d);
    bit par = 1'b0;
    exp_txd.push_back(1'b0);
    for (int i = 0; i < nb[k]; i++) begin
      exp_txd.push_back(d[i]);
      par ^= d[i];
    end
    if (pm[k] == 1) exp_txd.push_back(par);
    if (pm[k] == 2) exp_txd.push_back(!par);
    for (int s = 0; s < ns[k]; s++) exp_txd.push_back(1'b1);
    ends.push_back(exp_txd.size());
  endtask

  task automatic do_tick(int k, int t);
    bit et;
    bit ed;
    et = (t < exp_txd.size()) ? exp_txd[t] : 1'b1;
    ed = 1'b0;
    foreach (ends[i]) if (ends[i] == t) ed = 1'b1;
    baud_tick = 1'b1;
    step();
    baud_tick = 1'b0;
    check($sformatf("txd%0d_t%0d", k, t), txd[k], et);
    check($sformatf("done%0d_t%0d", k, t), done[k], ed);
    check($sformatf("busy%0d_t%0d", k, t), busy[k], t < exp_txd.size());
    step();
    check($sformatf("done_pulse%0d_t%0d", k, t), done[k], 1'b0);
    repeat (6) step();
  endtask

  task automatic frame(int k, logic [7:0] d);
    clear_model();
    build(k, d);
    write(k, d);
    check($sformatf("tbr_full%0d", k), tbr[k], 1'b0);
    do_tick(k, 0);
    check($sformatf("tbr_free%0d", k), tbr[k], 1'b1);
    for (int t = 1; t <= exp_txd.size(); t++) do_tick(k, t);
  endtask

  initial begin
    logic [7:0] d;
    repeat (3) step();
    reset = 1'b1;
    repeat (10) step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_tbr%0d", k), tbr[k], 1'b1);
      check($sformatf("rst_txd%0d", k), txd[k], 1'b1);
      check($sformatf("rst_busy%0d", k), busy[k], 1'b0);
      check($sformatf("rst_done%0d", k), done[k], 1'b0);
    end

    frame(0, 8'hA5);
    check("idle_ignored1", txd[1], 1'b1);
    check("idle_ignored2", busy[2], 1'b0);
    repeat (3) frame(0, 8'($urandom));
    frame(1, 8'h13);
    frame(2, 8'h13);
    frame(1, 8'($urandom));
    frame(2, 8'($urandom));

    // Back-to-back: second frame queued right after the transfer, third write must be dropped.
    clear_model();
    build(0, 8'h3C);
    build(0, 8'hC3);
    write(0, 8'h3C);
    do_tick(0, 0);
    check("b2b_tbr_after_xfer", tbr[0], 1'b1);
    write(0, 8'hC3);
    check("b2b_tbr_full", tbr[0], 1'b0);
    write(0, 8'h55);
    check("b2b_tbr_still_full", tbr[0], 1'b0);
    for (int t = 1; t <= exp_txd.size(); t++) do_tick(0, t);
    check("b2b_tbr_end", tbr[0], 1'b1);

    // Asynchronous reset during data bit 4 with another byte pending.
    clear_model();
    build(0, 8'hFF);
    write(0, 8'hFF);
    for (int t = 0; t <= 5; t++) do_tick(0, t);
    write(0, 8'h00);
    check("mid_tbr_full", tbr[0], 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check("arst_tbr", tbr[0], 1'b1);
    check("arst_txd", txd[0], 1'b1);
    check("arst_busy", busy[0], 1'b0);
    #10;
    reset = 1'b1;
    step();
    frame(0, 8'($urandom));

`ifdef UART_TX_BREAK_EN
    d = 8'($urandom);
    send_break = 1'b1;
    write(0, d);
    step();
    check("brk_txd", txd[0], 1'b0);
    check("brk_tbr", tbr[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
      check($sformatf("brk_hold_txd%0d", i), txd[0], 1'b0);
      check($sformatf("brk_hold_busy%0d", i), busy[0], 1'b0);
      repeat (7) step();
    end
    send_break = 1'b0;
    step();
    check("brk_release_txd", txd[0], 1'b1);
    clear_model();
    build(0, d);
    do_tick(0, 0);
    check("brk_tbr_free", tbr[0], 1'b1);
    for (int t = 1; t <= exp_txd.size(); t++) do_tick(0, t);
`else
    d = 8'h00;
    check("no_brk_idle_txd", txd[0] | d[0], 1'b1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
